dcache_responder: RTL and testbench

//  Responder end of the datapath D-port: accepts read_b/write requests, returns resp_b/rdata_b.

---
 rtl/dcache_responder_pkg.sv | 18 +
 rtl/dcache_responder_if.sv | 30 +++
 rtl/dcache_responder_array.sv | 68 ++++++
 rtl/dcache_responder.sv | 171 +++++++++++++++++
 tb/tb_dcache_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
// Line size is fixed at 32 bytes; index/tag widths derive from NUM_SETS.
package dcache_types;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} dcache_state_t;
  typedef logic [255:0] cache_line_t;

  localparam int DCACHE_OFFSET_W = 5;

  function automatic int dcache_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int dcache_tag_w(input int num_sets);
    return 32 - DCACHE_OFFSET_W - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU D-port plus pmem line port of the data cache, bundled as one bus.
// slave = cache side, master = CPU/memory environment side.
interface dcache_responder_if;
  import dcache_types::*;

  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  cache_line_t pmem_wdata;
  cache_line_t pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  read_b, write, wmask, address_b, wdata, pmem_rdata, pmem_resp,
    output resp_b, rdata_b, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output read_b, write, wmask, address_b, wdata, pmem_rdata, pmem_resp,
    input  resp_b, rdata_b, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/dcache_responder_array.sv
// Tag/valid/dirty/data storage for the data cache: combinational read of one set,
// byte-enabled store into that set, or a full-line fill that marks it valid and clean.
module dcache_array
  import dcache_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = dcache_index_w(NUM_SETS),
  parameter int TAG_W    = dcache_tag_w(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty,
  output cache_line_t      rd_line,
  input  logic             wr_en,
  input  logic [31:0]      wr_be,
  input  cache_line_t      wr_line,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  cache_line_t      fill_line
);

  cache_line_t         data_q [NUM_SETS];
  cache_line_t         data_d [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_line  = data_q[index];

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      data_d[index]  = fill_line;
      tag_d[index]   = fill_tag;
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end else if (wr_en) begin
      for (int b = 0; b < 32; b++)
        if (wr_be[b]) data_d[index][8*b +: 8] = wr_line[8*b +: 8];
      // An all-zero mask still marks the line dirty.
      dirty_d[index] = 1'b1;
    end
  end

  // Data and tags carry no reset; only the valid/dirty bits are cleared.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back write-allocate L1 D-cache responder: hits answer in the
// request cycle, misses run writeback/fill on pmem. Optional counters: DCACHE_PERF_CNT_EN.
module dcache_responder
  import dcache_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                clk,
  input  logic                rst,
  dcache_responder_if.slave   bus,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int IDX_W = dcache_index_w(NUM_SETS);
  localparam int TAG_W = dcache_tag_w(NUM_SETS);

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word;
  logic             req, hit, resp;
  logic             addr_unused;

  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid, rd_dirty;
  cache_line_t      rd_line;
  logic [31:0]      wr_be;
  logic             wr_en, fill_en;

  dcache_state_t    state_q, state_d;
  logic             pmem_read_q, pmem_read_d;
  logic             pmem_write_q, pmem_write_d;
  logic [31:0]      pmem_address_q, pmem_address_d;

  assign index       = bus.address_b[DCACHE_OFFSET_W +: IDX_W];
  assign req_tag     = bus.address_b[31 -: TAG_W];
  assign word        = bus.address_b[4:2];
  assign addr_unused = ^bus.address_b[1:0];

  assign req  = bus.read_b | bus.write;
  assign hit  = rd_valid && (rd_tag == req_tag);
  assign resp = !rst && (state_q == IDLE) && req && hit;

  // read_b and write together resolve as a write.
  assign wr_en = resp && bus.write;
  assign wr_be = {28'b0, bus.wmask} << {word, 2'b00};

  dcache_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_be     (wr_be),
    .wr_line   ({8{bus.wdata}}),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_line (bus.pmem_rdata)
  );

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    fill_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (rd_valid && rd_dirty) begin
            state_d        = WRITEBACK;
            pmem_write_d   = 1'b1;
            pmem_address_d = {rd_tag, index, 5'b0};
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag, index, 5'b0};
          end
        end
      end
      WRITEBACK: begin
        if (bus.pmem_resp) begin
          state_d        = FILL;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_address_d = {req_tag, index, 5'b0};
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          state_d     = IDLE;
          pmem_read_d = 1'b0;
          fill_en     = !rst;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
    end
  end

  assign bus.resp_b       = resp;
  assign bus.rdata_b      = rd_line[{word, 5'b0} +: 32];
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  // The victim set stays selected throughout WRITEBACK because the request is held.
  assign bus.pmem_wdata   = rd_line;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        missed_q, missed_d;
  logic        miss_start;

  assign miss_start = !rst && (state_q == IDLE) && req && !hit;

  // missed_q keeps the response that ends a miss from also counting as a hit.
  always_comb begin
    missed_d     = missed_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (resp) begin
      missed_d = 1'b0;
      if (!missed_q && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start) begin
      missed_d = 1'b1;
      if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      missed_q     <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      missed_q     <= missed_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

`ifndef SYNTHESIS
  a_no_rw_both: assert property (@(posedge clk) disable iff (rst) !(bus.read_b && bus.write));
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed + randomized bench for dcache_responder: checks a flat coherent-memory view,
// residency-based hit/miss/writeback prediction, miss latency and counters.
module tb_dcache_responder;
  import dcache_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_responder_if bus();

  dcache_responder #(.NUM_SETS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Coherent memory as the CPU should see it, plus the backing store behind pmem.
  logic [31:0] cmem   [int];
  cache_line_t pstore [int];
  // Which line each set holds, in the abstract.
  bit          mvalid [8];
  bit          mdirty [8];
  logic [23:0] mtag   [8];
  int          mhits, mmisses;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wkey(input logic [31:0] a);
    return int'({2'b00, a[31:2]});
  endfunction

  function automatic int lkey(input logic [31:0] a);
    return int'({a[31:5], 5'b0});
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:2] == 30'h10) return 32'h1122_3344;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic cache_line_t store_line(input logic [31:0] la);
    cache_line_t l;
    if (pstore.exists(lkey(la))) return pstore[lkey(la)];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word({la[31:5], 5'b0} + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    cache_line_t l;
    if (cmem.exists(wkey(a))) return cmem[wkey(a)];
    l = store_line(a);
    return l[32*a[4:2] +: 32];
  endfunction

  function automatic cache_line_t model_line(input logic [31:0] la);
    cache_line_t l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = model_word({la[31:5], 5'b0} + 32'(4*w));
    return l;
  endfunction

  // A reset loses dirty lines: those words fall back to the backing store.
  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      if (mvalid[s] && mdirty[s])
        for (int w = 0; w < 8; w++) cmem.delete(wkey({mtag[s], 3'(s), 3'(w), 2'b00}));
      mvalid[s] = 0;
      mdirty[s] = 0;
    end
    mhits   = 0;
    mmisses = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one request (starting just after a posedge), plays pmem, returns what happened.
  task automatic cpu_req(input bit wr, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, input int l1, input int l2,
                         output int cyc, output int nwb, output int nfill,
                         output logic [31:0] wb_addr, output cache_line_t wb_data,
                         output logic [31:0] fill_addr, output logic [31:0] rd);
    int  wait_n;
    bit  done;
    bus.read_b = !wr; bus.write = wr; bus.address_b = a; bus.wmask = m; bus.wdata = d;
    cyc = 0; nwb = 0; nfill = 0; wait_n = 0; done = 0;
    wb_addr = '0; wb_data = '0; fill_addr = '0; rd = 'x;
    while (!done && cyc < 100) begin
      @(negedge clk);
      chk("pmem_excl", bus.pmem_read & bus.pmem_write, 0);
      if (bus.resp_b) begin
        rd   = bus.rdata_b;
        done = 1;
      end else if (bus.pmem_write) begin
        if (wait_n == 0) begin nwb++; wb_addr = bus.pmem_address; wb_data = bus.pmem_wdata; end
        wait_n++;
        if (wait_n == l1) begin
          pstore[lkey(wb_addr)] = model_line(wb_addr);
          bus.pmem_resp = 1'b1;
        end
      end else if (bus.pmem_read) begin
        if (wait_n == 0) begin nfill++; fill_addr = bus.pmem_address; end
        wait_n++;
        if (wait_n == l2) begin
          bus.pmem_rdata = store_line(fill_addr);
          bus.pmem_resp  = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (bus.pmem_resp) begin bus.pmem_resp = 1'b0; wait_n = 0; end
      if (!done) cyc++;
    end
    bus.read_b = 1'b0; bus.write = 1'b0;
    chk("resp_seen", done, 1);
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input int l1, input int l2, output logic [31:0] rd);
    logic [2:0]  idx;
    logic [23:0] tg;
    bit          hit, dirty_v;
    logic [31:0] victim, exp_rd, wb_addr, fill_addr, merged;
    cache_line_t exp_vline, wb_data;
    int          cyc, nwb, nfill, exp_lat;
    idx = a[7:5]; tg = a[31:8];
    hit       = mvalid[idx] && (mtag[idx] == tg);
    dirty_v   = !hit && mvalid[idx] && mdirty[idx];
    victim    = {mtag[idx], idx, 5'b0};
    exp_vline = model_line(victim);
    exp_rd    = model_word(a);
    exp_lat   = hit ? 0 : (dirty_v ? l1 + l2 + 1 : l2 + 1);
    cpu_req(wr, a, m, d, l1, l2, cyc, nwb, nfill, wb_addr, wb_data, fill_addr, rd);
    chk("latency", cyc, exp_lat);
    chk("wb_count", nwb, dirty_v);
    chk("fill_count", nfill, !hit);
    if (dirty_v) begin
      chk("wb_addr", wb_addr, victim);
      chk("wb_data", wb_data, exp_vline);
    end
    if (!hit) chk("fill_addr", fill_addr, {a[31:5], 5'b0});
    if (!wr) chk("rdata", rd, exp_rd);
    if (hit) mhits++;
    else begin
      mmisses++;
      mvalid[idx] = 1; mtag[idx] = tg; mdirty[idx] = 0;
    end
    if (wr) begin
      merged = model_word(a);
      for (int b = 0; b < 4; b++) if (m[b]) merged[8*b +: 8] = d[8*b +: 8];
      cmem[wkey(a)] = merged;
      mdirty[idx]   = 1;
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    bit          wr;
    rst = 1'b1;
    bus.read_b = 0; bus.write = 0; bus.wmask = 0; bus.address_b = 0; bus.wdata = 0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
    @(posedge clk); #1;
    do_reset();

    @(negedge clk);
    chk("rst_resp_b", bus.resp_b, 0);
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    @(posedge clk); #1;

    // 1: cold read miss, fill after 3 cycles
    access(0, 32'h40, 4'h0, 32'h0, 1, 3, rd);
    chk("t1_rdata", rd, 32'h1122_3344);
    // 2: same line hit
    access(0, 32'h44, 4'h0, 32'h0, 1, 1, rd);
    // 3: partial write then read back
    access(1, 32'h40, 4'b0011, 32'hAAAA_BBBB, 1, 1, rd);
    access(0, 32'h40, 4'h0, 32'h0, 1, 1, rd);
    chk("t3_rdata", rd, 32'h1122_BBBB);
    // 4: conflicting tag on index 2 forces writeback of the dirty line
    access(0, 32'h140, 4'h0, 32'h0, 2, 3, rd);
    chk("t4_wb_stored", pstore[lkey(32'h40)][31:0], 32'h1122_BBBB);
`ifdef DCACHE_PERF_CNT_EN
    chk("t6_hit_count", hit_count, 3);
    chk("t6_miss_count", miss_count, 2);
`else
    chk("t6_hit_count", hit_count, 0);
    chk("t6_miss_count", miss_count, 0);
`endif

    // 5: reset in the middle of a fill; a late pmem_resp must be ignored
    bus.read_b = 1'b1; bus.write = 1'b0; bus.address_b = 32'h80;
    @(negedge clk);
    chk("t5_no_resp", bus.resp_b, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_fill_req", bus.pmem_read, 1);
    chk("t5_fill_addr", bus.pmem_address, 32'h80);
    rst = 1'b1; bus.read_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    bus.pmem_resp = 1'b1; bus.pmem_rdata = '1;
    @(negedge clk);
    chk("t5_pmem_read_off", bus.pmem_read, 0);
    chk("t5_pmem_write_off", bus.pmem_write, 0);
    chk("t5_hit_count_clr", hit_count, 0);
    chk("t5_miss_count_clr", miss_count, 0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    chk("t5_late_resp_ignored", bus.pmem_read | bus.pmem_write | bus.resp_b, 0);
    @(posedge clk); #1;
    access(0, 32'h44, 4'h0, 32'h0, 1, 2, rd);

    // Random traffic over 4 tags x 8 sets with random pmem latency and occasional reset
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      a  = {22'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      access(wr, a, 4'($urandom), $urandom, $urandom_range(1, 4), $urandom_range(1, 4), rd);
    end
    @(negedge clk);
`ifdef DCACHE_PERF_CNT_EN
    chk("final_hit_count", hit_count, 32'(mhits));
    chk("final_miss_count", miss_count, 32'(mmisses));
`else
    chk("final_hit_count", hit_count, 0);
    chk("final_miss_count", miss_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
